// File: rtl/count_uart_pkg.sv
// Shared types and constants for the counter-snapshot UART transmitter.
package count_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/count_uart_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit so full and empty are
// distinguished by comparing the MSBs.
module count_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW:0]      w_diff;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_diff    = r_wr_ptr - r_rd_ptr;
  assign o_level   = LW'(w_diff);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/count_uart_tx.sv
// UART 8N1 transmitter for counter snapshots: valid/ready in, byte FIFO, serial out.
// IDLE: line high, waiting | START: start bit | DATA: 8 bits LSB first | STOP: stop bit
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

  uart_state_t          r_state;
  uart_state_t          w_state_nxt;
  logic [BW-1:0]        r_baud;
  logic [BW-1:0]        w_baud_nxt;
  logic [IW-1:0]        r_bit_idx;
  logic [IW-1:0]        w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_baud_done;
  logic [DATA_BITS-1:0] w_fifo_data;

  assign in_ready    = !w_full && ena;
  assign w_push      = in_valid && in_ready;
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign tx          = r_tx;
  assign busy        = (r_state != IDLE) || !w_empty;

  count_uart_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // tx is registered from the next-state values so the start bit appears on
  // the same edge that leaves IDLE or STOP.
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_pop         = 1'b0;
    if (ena) begin
      case (r_state)
        IDLE: begin
          w_tx_nxt = 1'b1;
          if (!w_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_fifo_data;
            w_baud_nxt    = '0;
            w_bit_idx_nxt = '0;
            w_state_nxt   = START;
            w_tx_nxt      = 1'b0;
          end
        end
        START: begin
          w_tx_nxt = 1'b0;
          if (w_baud_done) begin
            w_baud_nxt  = '0;
            w_state_nxt = DATA;
            w_tx_nxt    = r_shift[0];
          end else begin
            w_baud_nxt = r_baud + BW'(1);
          end
        end
        DATA: begin
          if (w_baud_done) begin
            w_baud_nxt    = '0;
            w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
            w_bit_idx_nxt = r_bit_idx + IW'(1);
            if (r_bit_idx == BIT_LAST) begin
              w_state_nxt = STOP;
              w_tx_nxt    = 1'b1;
            end else begin
              w_tx_nxt = r_shift[1];
            end
          end else begin
            w_baud_nxt = r_baud + BW'(1);
          end
        end
        STOP: begin
          w_tx_nxt = 1'b1;
          if (w_baud_done) begin
            w_baud_nxt = '0;
            if (!w_empty) begin
              w_pop         = 1'b1;
              w_shift_nxt   = w_fifo_data;
              w_bit_idx_nxt = '0;
              w_state_nxt   = START;
              w_tx_nxt      = 1'b0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_baud_nxt = r_baud + BW'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end
endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx: frame-level reference model, serial decoder and directed plus random traffic.
module tb_count_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          ena      = 1'b1;
  logic [7:0]    in_data  = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic [LW-1:0] level;

  count_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .level    (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, transmitter as "cycles left in the current frame".
  byte unsigned m_q[$];
  byte unsigned sb_q[$];
  int           m_frame   = 0;
  logic [7:0]   m_cur     = 8'h00;
  bit           m_acc     = 1'b0;
  bit           m_refused = 1'b0;
  int           m_pre;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_frame   = 0;
      m_acc     = 1'b0;
      m_refused = 1'b0;
    end else begin
      m_acc     = 1'b0;
      m_refused = 1'b0;
      if (ena) begin
        m_pre = m_q.size();
        m_acc = in_valid && (m_pre < DEPTH);
        if (m_pre > 0 && m_frame <= 1) begin
          m_cur     = m_q.pop_front();
          sb_q.push_back(m_cur);
          m_frame   = 10 * CPB;
          m_refused = in_valid && (m_pre == DEPTH);
        end else if (m_frame > 0) begin
          m_frame--;
        end
        if (m_acc) m_q.push_back(in_data);
      end
    end
  end

  function automatic logic exp_tx();
    int k;
    if (m_frame == 0) return 1'b1;
    k = (10 * CPB - m_frame) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check_val("tx", tx, exp_tx());
      check_val("in_ready", in_ready, (m_q.size() < DEPTH) && ena);
      check_val("busy", busy, (m_frame > 0) || (m_q.size() > 0));
      check_val("level", level, m_q.size());
    end
  end

  // Serial decoder: counts only cycles in which the line was allowed to advance.
  logic       ena_q    = 1'b1;
  int         rx_cnt   = -1;
  int         rx_idx   = 0;
  int         rx_total = 0;
  logic [7:0] rx_sh    = 8'h00;

  always @(posedge clk) ena_q <= ena;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_cnt = -1;
      rx_idx = sb_q.size();
    end else if (rx_cnt < 0) begin
      if (tx === 1'b0) rx_cnt = 0;
    end else if (ena_q) begin
      rx_cnt++;
      if (rx_cnt > CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2) begin
        rx_sh = {tx, rx_sh[7:1]};
      end else if (rx_cnt == 9 * CPB + CPB / 2) begin
        check_val("rx_stop", tx, 1);
        check_val("rx_expected", rx_idx < sb_q.size(), 1);
        if (rx_idx < sb_q.size()) begin
          check_val("rx_byte", rx_sh, sb_q[rx_idx]);
          rx_idx++;
        end
        rx_total++;
        rx_cnt = -1;
      end
    end
  end

  task automatic push_one(input logic [7:0] d);
    @(negedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int c;
    c = 0;
    while ((m_frame > 0 || m_q.size() > 0) && c < limit) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check_val(tag, busy, 0);
  endtask

  task automatic stream_bytes(input logic [7:0] base, input int n, input string tag);
    int idx;
    int c;
    int refusals;
    bit pend;
    bit saw_full;
    idx = 0; c = 0; refusals = 0; pend = 1'b0; saw_full = 1'b0;
    @(negedge clk); #1;
    in_valid = 1'b1;
    in_data  = base;
    while (idx < n && c < 500) begin
      @(negedge clk);
      c++;
      if (m_acc) idx++;
      if (pend) begin
        check_val({tag, "_retake_level"}, level, DEPTH);
        pend = 1'b0;
      end
      if (m_refused) begin
        check_val({tag, "_refused_level"}, level, DEPTH - 1);
        pend = 1'b1;
        refusals++;
      end
      if (m_q.size() == DEPTH) begin
        check_val({tag, "_full_ready"}, in_ready, 0);
        saw_full = 1'b1;
      end
      #1;
      if (idx < n) in_data = base + 8'(idx);
      else         in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check_val({tag, "_accepted"}, idx, n);
    check_val({tag, "_saw_full"}, saw_full, 1);
    check_val({tag, "_refusal_seen"}, refusals > 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected below 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    logic       s [80];
    int         c;
    int         k;
    int         z0;
    int         o1;
    int         z1;
    int         rx_before;

    repeat (3) @(negedge clk);
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_level", level, 0);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_val("t1_tx", tx, 1);
      check_val("t1_ready", in_ready, 1);
      check_val("t1_busy", busy, 0);
      check_val("t1_level", level, 0);
    end

    // Single 0xA5 frame against a literal waveform.
    pat = {1'b1, 8'hA5, 1'b0};
    @(negedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    check_val("t2_tx_before", tx, 1);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      check_val($sformatf("t2_cyc%0d", i), tx, pat[i / CPB]);
    end
    @(negedge clk);
    check_val("t2_busy_after", busy, 0);
    check_val("t2_tx_after", tx, 1);

    // Six bytes with in_valid held: back-pressure, ordering, back-to-back frames.
    rx_before = rx_total;
    stream_bytes(8'h01, 6, "t3");
    wait_idle("t3_drain", 400);
    check_val("t3_rx_count", rx_total - rx_before, 6);

    // Full FIFO with a pop on the same edge as a pending push.
    rx_before = rx_total;
    stream_bytes(8'h10, 6, "t4");
    wait_idle("t4_drain", 400);
    check_val("t4_rx_count", rx_total - rx_before, 6);

    // Reset in the middle of a data bit with two bytes queued.
    push_one(8'h3C);
    push_one(8'h11);
    push_one(8'h22);
    c = 0;
    while (!(m_frame > 0 && (10 * CPB - m_frame) == 6) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check_val("t5_pre_tx", tx, 0);
    check_val("t5_pre_level", level, 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_tx", tx, 1);
    check_val("t5_rst_level", level, 0);
    check_val("t5_rst_busy", busy, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    rx_before = rx_total;
    push_one(8'h55);
    wait_idle("t5_drain", 200);
    check_val("t5_rx_count", rx_total - rx_before, 1);

    // Freeze for 7 cycles inside data bit 3 of 0x08 (the only high data bit).
    push_one(8'h08);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      s[i] = tx;
      if (i == 20) check_val("t6_ready_frozen", in_ready, 0);
      #1;
      if (i == 17) ena = 1'b0;
      if (i == 24) ena = 1'b1;
    end
    k = 0; z0 = 0; o1 = 0; z1 = 0;
    while (k < 80 && s[k] == 1'b0) begin z0++; k++; end
    while (k < 80 && s[k] == 1'b1) begin o1++; k++; end
    while (k < 80 && s[k] == 1'b0) begin z1++; k++; end
    check_val("t6_low_run", z0, 4 * CPB);
    check_val("t6_bit3_len", o1, CPB + 7);
    check_val("t6_low_run2", z1, 4 * CPB);
    wait_idle("t6_drain", 200);

    // Random traffic with random enable gaps.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk); #1;
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      ena      = ($urandom_range(0, 9) != 0);
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    ena      = 1'b1;
    wait_idle("rand_drain", 2000);
    check_val("rand_all_rx", rx_idx, sb_q.size());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
